// File: rtl/alu_select_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_select_mux_if
//  Description : Bus bundle for the ALU operand/result select datapath.
//                master drives operands, B-invert and op select and
//                receives the registered result; slave is the datapath.
//  Signals     : in_valid, in1, in2, bi, op   (master -> slave)
//                out_valid, result, cout      (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_select_mux_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             bi;
    logic [1:0]       op;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output in_valid, in1, in2, bi, op,
        input  out_valid, result, cout
    );

    modport slave (
        input  in_valid, in1, in2, bi, op,
        output out_valid, result, cout
    );
endinterface
`default_nettype wire

// File: rtl/alu_select_mux.sv
`default_nettype none
// ============================================================================
//  Module      : alu_select_mux
//  Description : Registered operand-select (in2 / ~in2) and result-select
//                (AND / OR / ADD / op3) stage of the ALU. One-cycle latency,
//                one sample per cycle, no backpressure.
//  Ports       : clk      - rising-edge clock
//                rst_n    - asynchronous active-low reset
//                alu_bus  - alu_select_mux_if.slave (operands in, result out)
//  Options     : ALU_SLT_EN - when defined, op=11 returns signed in1<in2
//                (subtraction forced); otherwise op=11 returns zero.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_select_mux #(
    parameter int WIDTH = 32
) (
    input  wire               clk,
    input  wire               rst_n,
    alu_select_mux_if.slave   alu_bus
);
    localparam logic [1:0] c_OP_AND = 2'b00;
    localparam logic [1:0] c_OP_OR  = 2'b01;
    localparam logic [1:0] c_OP_ADD = 2'b10;
    localparam logic [1:0] c_OP_3   = 2'b11;

    logic             bi_eff;
    logic [WIDTH-1:0] bmux;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] op3_val;
    logic [WIDTH-1:0] mux_out;

    logic [WIDTH-1:0] result_d, result_q;
    logic             cout_d, cout_q;
    logic             out_valid_d, out_valid_q;

`ifdef ALU_SLT_EN
    logic sub_ovf;
    logic slt;

    // op3 needs in1 - in2, so the invert/carry-in is forced on for it.
    assign bi_eff  = alu_bus.bi | (alu_bus.op == c_OP_3);
    // Signed overflow of a subtraction: operand signs differ and the
    // difference's sign differs from in1's sign.
    assign sub_ovf = (alu_bus.in1[WIDTH-1] != alu_bus.in2[WIDTH-1]) &&
                     (sum_full[WIDTH-1] != alu_bus.in1[WIDTH-1]);
    assign slt     = sum_full[WIDTH-1] ^ sub_ovf;
    assign op3_val = {{(WIDTH-1){1'b0}}, slt};
`else
    assign bi_eff  = alu_bus.bi;
    assign op3_val = '0;
`endif

    // bi doubles as the adder carry-in, so bi=1 yields in1 + ~in2 + 1.
    assign bmux     = bi_eff ? ~alu_bus.in2 : alu_bus.in2;
    assign sum_full = {1'b0, alu_bus.in1} + {1'b0, bmux} + {{WIDTH{1'b0}}, bi_eff};

    always_comb begin
        mux_out = '0;
        case (alu_bus.op)
            c_OP_AND: mux_out = alu_bus.in1 & alu_bus.in2;
            c_OP_OR:  mux_out = alu_bus.in1 | alu_bus.in2;
            c_OP_ADD: mux_out = sum_full[WIDTH-1:0];
            c_OP_3:   mux_out = op3_val;
            default:  mux_out = '0;
        endcase
    end

    // Adder always runs, so cout is captured for every op.
    always_comb begin
        result_d    = result_q;
        cout_d      = cout_q;
        out_valid_d = alu_bus.in_valid;
        if (alu_bus.in_valid) begin
            result_d = mux_out;
            cout_d   = sum_full[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign alu_bus.result    = result_q;
    assign alu_bus.cout      = cout_q;
    assign alu_bus.out_valid = out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_select_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_select_mux
//  Description : Scoreboard bench for alu_select_mux: stimulus pushes the
//                model's expected result, a negedge monitor pops/compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_select_mux;
    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             cout;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb_q[$];
    exp_t last_exp;

    alu_select_mux_if #(.WIDTH(WIDTH)) alu_bus ();

    alu_select_mux #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .alu_bus (alu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: arithmetic view of the ALU rules.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bi, input logic [1:0] op);
        exp_t e;
        longint unsigned ua, ub, s;
        logic sub;
        ua  = longint'(a);
        ub  = longint'(b);
        sub = bi;
`ifdef ALU_SLT_EN
        if (op == 2'b11) sub = 1'b1;
`endif
        if (sub) begin
            s        = (ua - ub) & 64'hFFFF_FFFF;
            e.cout   = (ua >= ub);
        end else begin
            s        = ua + ub;
            e.cout   = (s >= 64'h1_0000_0000);
            s        = s & 64'hFFFF_FFFF;
        end
        case (op)
            2'b00:   e.result = a & b;
            2'b01:   e.result = a | b;
            2'b10:   e.result = s[WIDTH-1:0];
`ifdef ALU_SLT_EN
            default: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`else
            default: e.result = '0;
`endif
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compares every presented output against the scoreboard and
    // checks that idle cycles hold the previous value.
    always @(negedge clk) begin
        if (rst_n) begin
            if (alu_bus.out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", {alu_bus.cout, alu_bus.result}, '0);
                    bad += (total > 0 && ({alu_bus.cout, alu_bus.result} === '0)) ? 1 : 0;
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result", {1'b0, alu_bus.result}, {1'b0, e.result});
                    check("cout",   {{WIDTH{1'b0}}, alu_bus.cout}, {{WIDTH{1'b0}}, e.cout});
                    last_exp = e;
                end
            end else begin
                check("hold_out_valid", {{WIDTH{1'b0}}, alu_bus.out_valid}, '0);
                check("hold_value", {alu_bus.cout, alu_bus.result}, {last_exp.cout, last_exp.result});
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bi, input logic [1:0] op);
        alu_bus.in_valid = 1'b1;
        alu_bus.in1      = a;
        alu_bus.in2      = b;
        alu_bus.bi       = bi;
        alu_bus.op       = op;
        sb_q.push_back(model(a, b, bi, op));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            alu_bus.in_valid = 1'b0;
            alu_bus.in1      = $urandom;
            alu_bus.in2      = $urandom;
            alu_bus.bi       = 1'($urandom);
            alu_bus.op       = 2'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int wait_cnt;
        total    = 0;
        bad      = 0;
        last_exp = '0;
        rst_n    = 1'b0;
        alu_bus.in_valid = 1'b0;
        alu_bus.in1 = '0;
        alu_bus.in2 = '0;
        alu_bus.bi  = 1'b0;
        alu_bus.op  = 2'b00;
        #1;
        check("reset_result",    {1'b0, alu_bus.result}, '0);
        check("reset_cout",      {{WIDTH{1'b0}}, alu_bus.cout}, '0);
        check("reset_out_valid", {{WIDTH{1'b0}}, alu_bus.out_valid}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases.
        send(32'd5, 32'd2, 1'b0, 2'b00);
        send(32'd5, 32'd2, 1'b0, 2'b01);
        send(32'd5, 32'd2, 1'b0, 2'b10);
        send(32'd5, 32'd2, 1'b1, 2'b10);
        send(32'd2, 32'd5, 1'b1, 2'b10);
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 2'b10);
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 2'b11);
        send(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 2'b11);
        send(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 2'b11);
        idle(2);
        // Back-to-back ops then idle hold.
        send(32'hA5A5_0F0F, 32'h0FF0_1234, 1'b0, 2'b00);
        send(32'hA5A5_0F0F, 32'h0FF0_1234, 1'b0, 2'b01);
        send(32'hA5A5_0F0F, 32'h0FF0_1234, 1'b1, 2'b10);
        send(32'hA5A5_0F0F, 32'h0FF0_1234, 1'b0, 2'b11);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0)
                send(pick_operand(), pick_operand(), 1'($urandom), 2'($urandom));
            else
                idle(1);
        end
        idle(2);

        // Asynchronous reset while out_valid is high.
        send(32'h1234_5678, 32'h0000_0001, 1'b0, 2'b10);
        alu_bus.in_valid = 1'b0;
        #1;
        check("pre_reset_out_valid", {{WIDTH{1'b0}}, alu_bus.out_valid}, {{WIDTH{1'b0}}, 1'b1});
        rst_n = 1'b0;
        #1;
        check("async_reset_result",    {1'b0, alu_bus.result}, '0);
        check("async_reset_cout",      {{WIDTH{1'b0}}, alu_bus.cout}, '0);
        check("async_reset_out_valid", {{WIDTH{1'b0}}, alu_bus.out_valid}, '0);
        sb_q.delete();
        last_exp = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(32'd7, 32'd9, 1'b1, 2'b10);
        idle(1);

        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        check("scoreboard_drained", WIDTH'(sb_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
